// File: rtl/store_pack.sv
// Store packer: turns a CPU byte/half/word store into one word-aligned,
// lane-replicated memory write with byte enables, an ack handshake and a timeout.
module store_pack #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [1:0]  st_size,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    output logic        st_done,
    output logic        st_err
);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_e;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 32'd1);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic        st_ready_q, st_ready_d;
    logic        mem_req_q, mem_req_d;
    logic        st_done_q, st_done_d;
    logic        st_err_q, st_err_d;

    logic [31:0] lane_wdata_s;
    logic [3:0]  lane_be_s;
    logic        bad_s;

    // Lane steering and legality check of the incoming store
    always_comb begin
        lane_wdata_s = 32'h0000_0000;
        lane_be_s    = 4'b0000;
        bad_s        = 1'b0;
        case (st_size)
            2'b00: begin
                lane_wdata_s = {4{st_data[7:0]}};
                lane_be_s    = 4'b0001 << st_addr[1:0];
            end
            2'b01: begin
                lane_wdata_s = {2{st_data[15:0]}};
                lane_be_s    = st_addr[1] ? 4'b1100 : 4'b0011;
                bad_s        = st_addr[0];
            end
            2'b10: begin
                lane_wdata_s = st_data;
                lane_be_s    = 4'b1111;
                bad_s        = |st_addr[1:0];
            end
            default: begin
                bad_s = 1'b1;
            end
        endcase
    end

    // Next-state, counter and output computation
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        st_done_d   = 1'b0;
        st_err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (st_valid) begin
                    if (bad_s) begin
                        st_err_d = 1'b1;
                    end else begin
                        state_d     = REQ;
                        cnt_d       = 16'd0;
                        mem_addr_d  = {st_addr[31:2], 2'b00};
                        mem_wdata_d = lane_wdata_s;
                        mem_be_d    = lane_be_s;
                    end
                end else begin
                    cnt_d = 16'd0;
                end
            end
            REQ: begin
                // Ack wins over a timeout landing in the same cycle
                if (mem_ack) begin
                    state_d   = IDLE;
                    cnt_d     = 16'd0;
                    st_done_d = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = IDLE;
                    cnt_d    = 16'd0;
                    st_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 16'd0;
            end
        endcase
        st_ready_d = (state_d == IDLE);
        mem_req_d  = (state_d == REQ);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 16'd0;
            mem_addr_q  <= 32'h0000_0000;
            mem_wdata_q <= 32'h0000_0000;
            mem_be_q    <= 4'b0000;
            st_ready_q  <= 1'b1;
            mem_req_q   <= 1'b0;
            st_done_q   <= 1'b0;
            st_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            st_ready_q  <= st_ready_d;
            mem_req_q   <= mem_req_d;
            st_done_q   <= st_done_d;
            st_err_q    <= st_err_d;
        end
    end

    assign st_ready  = st_ready_q;
    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign st_done   = st_done_q;
    assign st_err    = st_err_q;

endmodule

// File: tb/tb_store_pack.sv
// Directed bench for store_pack: default-timeout instance for the main
// function plus a TIMEOUT=4 instance for the abort/priority boundary.
module tb_store_pack;

    logic        clk;
    logic        rst_n;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [1:0]  st_size;
    logic        mem_ack;

    logic        st_ready, mem_req, st_done, st_err;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    logic        t_ready, t_req, t_done, t_err;
    logic [31:0] t_addr, t_wdata;
    logic [3:0]  t_be;

    int checks;
    int failures;

    store_pack u_dut (
        .clk(clk), .rst_n(rst_n), .st_valid(st_valid), .st_ready(st_ready),
        .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ack(mem_ack), .st_done(st_done), .st_err(st_err)
    );

    store_pack #(.TIMEOUT(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .st_valid(st_valid), .st_ready(t_ready),
        .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
        .mem_req(t_req), .mem_addr(t_addr), .mem_wdata(t_wdata),
        .mem_be(t_be), .mem_ack(mem_ack), .st_done(t_done), .st_err(t_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_flags(input string tag);
        chk({tag, "_ready"}, 32'(st_ready), 32'd1);
        chk({tag, "_req"},   32'(mem_req),  32'd0);
        chk({tag, "_done"},  32'(st_done),  32'd0);
        chk({tag, "_err"},   32'(st_err),   32'd0);
    endtask

    task automatic put(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] data);
        st_valid = 1'b1;
        st_size  = size;
        st_addr  = addr;
        st_data  = data;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        st_valid = 1'b0; st_addr = 32'h0; st_data = 32'h0; st_size = 2'b00; mem_ack = 1'b0;
        rst_n = 1'b0;
        step(); step();
        idle_flags("rst");
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_be", 32'(mem_be), 32'h0);

        // Byte store accepted on the very first edge after reset release
        rst_n = 1'b1;
        put(2'b00, 32'h0000_1003, 32'h0000_00AB);
        step();
        st_valid = 1'b0;
        chk("b_req", 32'(mem_req), 32'd1);
        chk("b_ready", 32'(st_ready), 32'd0);
        chk("b_addr", mem_addr, 32'h0000_1000);
        chk("b_wdata", mem_wdata, 32'hABAB_ABAB);
        chk("b_be", 32'(mem_be), 32'h8);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("b_done", 32'(st_done), 32'd1);
        chk("b_err", 32'(st_err), 32'd0);
        chk("b_req_off", 32'(mem_req), 32'd0);
        step();
        chk("b_done_1cyc", 32'(st_done), 32'd0);

        // Halfword, held through five unacknowledged cycles
        put(2'b01, 32'h0000_0042, 32'h1234_BEEF);
        step();
        st_valid = 1'b0;
        chk("h_wdata", mem_wdata, 32'hBEEF_BEEF);
        chk("h_be", 32'(mem_be), 32'hC);
        chk("h_addr", mem_addr, 32'h0000_0040);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("h_hold_req", 32'(mem_req), 32'd1);
            chk("h_hold_wdata", mem_wdata, 32'hBEEF_BEEF);
            chk("h_hold_be", 32'(mem_be), 32'hC);
            chk("h_hold_addr", mem_addr, 32'h0000_0040);
        end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("h_done", 32'(st_done), 32'd1);
        step();

        // Misaligned word, then reserved size
        put(2'b10, 32'h0000_0006, 32'h5555_5555);
        step();
        st_valid = 1'b0;
        chk("mis_err", 32'(st_err), 32'd1);
        chk("mis_req", 32'(mem_req), 32'd0);
        chk("mis_ready", 32'(st_ready), 32'd1);
        step();
        idle_flags("mis_after");
        put(2'b11, 32'h0000_0100, 32'h6666_6666);
        step();
        st_valid = 1'b0;
        chk("rsv_err", 32'(st_err), 32'd1);
        chk("rsv_req", 32'(mem_req), 32'd0);
        chk("rsv_ready", 32'(st_ready), 32'd1);
        step();
        idle_flags("rsv_after");

        // Ack while idle has no effect
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        idle_flags("idle_ack");

        // Back-to-back word stores with immediate ack
        put(2'b10, 32'h0000_0020, 32'h1111_1111);
        step();
        chk("bb1_req", 32'(mem_req), 32'd1);
        chk("bb1_wdata", mem_wdata, 32'h1111_1111);
        chk("bb1_be", 32'(mem_be), 32'hF);
        mem_ack = 1'b1;
        put(2'b10, 32'h0000_0024, 32'h2222_2222);
        step();
        chk("bb1_done", 32'(st_done), 32'd1);
        chk("bb_gap_req", 32'(mem_req), 32'd0);
        chk("bb_gap_ready", 32'(st_ready), 32'd1);
        step();
        st_valid = 1'b0;
        chk("bb2_req", 32'(mem_req), 32'd1);
        chk("bb2_addr", mem_addr, 32'h0000_0024);
        chk("bb2_wdata", mem_wdata, 32'h2222_2222);
        chk("bb2_done_low", 32'(st_done), 32'd0);
        step();
        mem_ack = 1'b0;
        chk("bb2_done", 32'(st_done), 32'd1);
        step();

        // Reset two cycles into REQ abandons the store silently
        put(2'b10, 32'h0000_0030, 32'h3333_3333);
        step();
        st_valid = 1'b0;
        step();
        chk("rr_req_before", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rr_req_async", 32'(mem_req), 32'd0);
        chk("rr_addr_async", mem_addr, 32'h0);
        chk("rr_be_async", 32'(mem_be), 32'h0);
        step();
        rst_n = 1'b1;
        step();
        idle_flags("rr_release");
        step();
        idle_flags("rr_release2");
        put(2'b10, 32'h0000_0040, 32'h4444_4444);
        step();
        st_valid = 1'b0;
        chk("rr_next_req", 32'(mem_req), 32'd1);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("rr_next_done", 32'(st_done), 32'd1);

        // TIMEOUT=4 instance: abort after four REQ cycles
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        put(2'b10, 32'h0000_0010, 32'h7777_7777);
        step();
        st_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("to_req_high", 32'(t_req), 32'd1);
            chk("to_err_low", 32'(t_err), 32'd0);
            step();
        end
        chk("to_err", 32'(t_err), 32'd1);
        chk("to_done", 32'(t_done), 32'd0);
        chk("to_req_off", 32'(t_req), 32'd0);
        chk("to_ready", 32'(t_ready), 32'd1);
        step();
        chk("to_err_1cyc", 32'(t_err), 32'd0);

        // Ack on the final count cycle wins over the timeout
        put(2'b10, 32'h0000_0010, 32'h8888_8888);
        step();
        st_valid = 1'b0;
        step(); step(); step();
        chk("tp_req_last", 32'(t_req), 32'd1);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("tp_done", 32'(t_done), 32'd1);
        chk("tp_err", 32'(t_err), 32'd0);
        step();
        chk("tp_done_1cyc", 32'(t_done), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
